// File: rtl/vickrey_auction_seq.sv
// Streaming sealed-bid auction: tracks best and second-best bid per round, reports winner/price on a held result handshake.
// Optional reserve-price floor is enabled with `define AUCTION_RESERVE_EN.
module vickrey_auction_seq #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   bid,
    input  logic           bid_valid,
    input  logic           bid_last,
    output logic           bid_ready,
    input  logic           second_price,
`ifdef AUCTION_RESERVE_EN
    input  logic [W-1:0]   reserve,
`endif
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N-1:0]   winner,
    output logic [W-1:0]   winning_bid,
    output logic [W-1:0]   price,
    output logic           sold,
    output logic [N:0]     num_bids
);

    typedef enum logic {COLLECT, RESULT} state_t;

    localparam logic [N:0] MAX_BIDS = (N+1)'(2**N);

    state_t         state_reg, state_next;
    logic [W-1:0]   best_reg, best_next;
    logic [W-1:0]   second_reg, second_next;
    logic [N-1:0]   widx_reg, widx_next;
    logic [N:0]     cnt_reg, cnt_next;
    logic           sp_reg, sp_next;
    logic [N-1:0]   winner_reg, winner_next;
    logic [W-1:0]   winning_bid_reg, winning_bid_next;
    logic [W-1:0]   price_reg, price_next;
    logic           sold_reg, sold_next;
    logic [N:0]     num_bids_reg, num_bids_next;

    logic           accept;
    logic           first_bid;
    logic           sp_eff;
    logic           close;
    logic [N:0]     cnt_inc;
    logic [W-1:0]   price_cand;

`ifdef AUCTION_RESERVE_EN
    logic [W-1:0]   reserve_reg, reserve_next;
    logic [W-1:0]   reserve_eff;
`endif

    assign bid_ready   = (state_reg == COLLECT);
    assign res_valid   = (state_reg == RESULT);
    assign winner      = winner_reg;
    assign winning_bid = winning_bid_reg;
    assign price       = price_reg;
    assign sold        = sold_reg;
    assign num_bids    = num_bids_reg;

    assign accept    = (state_reg == COLLECT) && bid_valid;
    assign first_bid = (cnt_reg == '0);
    // Mode is taken live on the opening bid so a one-bid round already sees it.
    assign sp_eff    = first_bid ? second_price : sp_reg;
    assign cnt_inc   = cnt_reg + 1'b1;
    assign close     = accept && (bid_last || (cnt_inc == MAX_BIDS));
`ifdef AUCTION_RESERVE_EN
    assign reserve_eff = first_bid ? reserve : reserve_reg;
`endif

    always_comb begin
        state_next       = state_reg;
        best_next        = best_reg;
        second_next      = second_reg;
        widx_next        = widx_reg;
        cnt_next         = cnt_reg;
        sp_next          = sp_reg;
        winner_next      = winner_reg;
        winning_bid_next = winning_bid_reg;
        price_next       = price_reg;
        sold_next        = sold_reg;
        num_bids_next    = num_bids_reg;
        price_cand       = '0;
`ifdef AUCTION_RESERVE_EN
        reserve_next     = reserve_reg;
`endif
        case (state_reg)
            COLLECT: begin
                if (accept) begin
                    cnt_next = cnt_inc;
                    if (first_bid) begin
                        sp_next = second_price;
`ifdef AUCTION_RESERVE_EN
                        reserve_next = reserve;
`endif
                    end
                    // Strict compare: an equal bid leaves the earlier winner but lifts the runner-up.
                    if (bid > best_reg) begin
                        second_next = best_reg;
                        best_next   = bid;
                        widx_next   = cnt_reg[N-1:0];
                    end else if (bid > second_reg) begin
                        second_next = bid;
                    end
                    if (close) begin
                        price_cand       = sp_eff ? second_next : best_next;
                        winner_next      = widx_next;
                        winning_bid_next = best_next;
                        price_next       = price_cand;
                        sold_next        = 1'b1;
                        num_bids_next    = cnt_inc;
`ifdef AUCTION_RESERVE_EN
                        if (best_next < reserve_eff) begin
                            winner_next      = '0;
                            winning_bid_next = '0;
                            price_next       = '0;
                            sold_next        = 1'b0;
                        end else if (price_cand < reserve_eff) begin
                            price_next = reserve_eff;
                        end
`endif
                        state_next = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    best_next   = '0;
                    second_next = '0;
                    widx_next   = '0;
                    cnt_next    = '0;
                    state_next  = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= COLLECT;
            best_reg        <= '0;
            second_reg      <= '0;
            widx_reg        <= '0;
            cnt_reg         <= '0;
            sp_reg          <= 1'b0;
            winner_reg      <= '0;
            winning_bid_reg <= '0;
            price_reg       <= '0;
            sold_reg        <= 1'b0;
            num_bids_reg    <= '0;
`ifdef AUCTION_RESERVE_EN
            reserve_reg     <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            best_reg        <= best_next;
            second_reg      <= second_next;
            widx_reg        <= widx_next;
            cnt_reg         <= cnt_next;
            sp_reg          <= sp_next;
            winner_reg      <= winner_next;
            winning_bid_reg <= winning_bid_next;
            price_reg       <= price_next;
            sold_reg        <= sold_next;
            num_bids_reg    <= num_bids_next;
`ifdef AUCTION_RESERVE_EN
            reserve_reg     <= reserve_next;
`endif
        end
    end

endmodule

// File: tb/tb_vickrey_auction_seq.sv
// Scoreboard bench for vickrey_auction_seq (N=2, W=4); reserve scenarios run when AUCTION_RESERVE_EN is defined.
module tb_vickrey_auction_seq;

    localparam int N = 2;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   bid = '0;
    logic           bid_valid = 1'b0;
    logic           bid_last = 1'b0;
    logic           bid_ready;
    logic           second_price = 1'b0;
    logic [W-1:0]   reserve = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [N-1:0]   winner;
    logic [W-1:0]   winning_bid;
    logic [W-1:0]   price;
    logic           sold;
    logic [N:0]     num_bids;

    typedef struct {
        logic [N-1:0] winner;
        logic [W-1:0] wbid;
        logic [W-1:0] price;
        logic         sold;
        logic [N:0]   nb;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] stim [0:3];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    vickrey_auction_seq #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bid(bid),
        .bid_valid(bid_valid),
        .bid_last(bid_last),
        .bid_ready(bid_ready),
        .second_price(second_price),
`ifdef AUCTION_RESERVE_EN
        .reserve(reserve),
`endif
        .res_valid(res_valid),
        .res_ready(res_ready),
        .winner(winner),
        .winning_bid(winning_bid),
        .price(price),
        .sold(sold),
        .num_bids(num_bids)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set4(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
    endtask

    // Reference: highest bid (earliest on ties), runner-up = max of all other bids.
    task automatic model_push(input int n, input logic sp, input logic [W-1:0] rsv);
        exp_t e;
        logic [W-1:0] best, second;
        int widx;
        best = '0; second = '0; widx = 0;
        for (int i = 0; i < n; i++)
            if (i == 0 || stim[i] > best) begin best = stim[i]; widx = i; end
        for (int i = 0; i < n; i++)
            if (i != widx && stim[i] > second) second = stim[i];
        e.winner = widx[N-1:0];
        e.wbid   = best;
        e.price  = sp ? second : best;
        e.sold   = 1'b1;
        e.nb     = (N+1)'(n);
`ifdef AUCTION_RESERVE_EN
        if (best < rsv) begin
            e.winner = '0; e.wbid = '0; e.price = '0; e.sold = 1'b0;
        end else if (e.price < rsv) begin
            e.price = rsv;
        end
`else
        if (rsv != '0) e.sold = 1'b1;
`endif
        exp_q.push_back(e);
    endtask

    // Drives n bids; mode/reserve are flipped after the first bid to prove they are latched.
    task automatic run_round(input string name, input int n, input logic use_last,
                             input logic sp, input logic [W-1:0] rsv, input logic expect_close);
        int waited;
        if (expect_close) model_push(n, sp, rsv);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bid          = stim[i];
            bid_valid    = 1'b1;
            bid_last     = use_last && (i == n - 1);
            second_price = (i == 0) ? sp : ~sp;
            reserve      = (i == 0) ? rsv : ~rsv;
            waited = 0;
            while (!bid_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!bid_ready) begin
                checks++; errors++;
                $display("FAIL %s bid_ready_timeout: got %0b want 1", name, bid_ready);
            end
            @(negedge clk);
        end
        bid_valid = 1'b0;
        bid_last  = 1'b0;
        if (expect_close) begin
            checks++;
            if (res_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s latency: res_valid=%0b want 1", name, res_valid);
            end
        end
    endtask

    task automatic collect_result(input string name);
        int waited;
        exp_t e;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (res_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s res_timeout: res_valid=%0b queued=%0d", name, res_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        checks += 5;
        if (winner !== e.winner) begin errors++; $display("FAIL %s winner: got %0d want %0d", name, winner, e.winner); end
        if (winning_bid !== e.wbid) begin errors++; $display("FAIL %s winning_bid: got %0d want %0d", name, winning_bid, e.wbid); end
        if (price !== e.price) begin errors++; $display("FAIL %s price: got %0d want %0d", name, price, e.price); end
        if (sold !== e.sold) begin errors++; $display("FAIL %s sold: got %0b want %0b", name, sold, e.sold); end
        if (num_bids !== e.nb) begin errors++; $display("FAIL %s num_bids: got %0d want %0d", name, num_bids, e.nb); end
        $display("%s: winner=%0d winning_bid=%0d price=%0d sold=%0b num_bids=%0d", name, winner, winning_bid, price, sold, num_bids);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || bid_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s rearm: res_valid=%0b bid_ready=%0b want 0/1", name, res_valid, bid_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bid_ready !== 1'b1 || res_valid !== 1'b0 || winner !== '0 || winning_bid !== '0 ||
            price !== '0 || sold !== 1'b0 || num_bids !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%0b val=%0b win=%0d wb=%0d pr=%0d sold=%0b nb=%0d want 1/0/0/0/0/0/0",
                     name, bid_ready, res_valid, winner, winning_bid, price, sold, num_bids);
        end else
            $display("%s: outputs at reset values", name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_full_round();
        set4(4'd3, 4'd9, 4'd5, 4'd9);
        run_round("full_vickrey_tie", 4, 1'b0, 1'b1, 4'd0, 1'b1);
        collect_result("full_vickrey_tie");
        set4(4'd1, 4'd2, 4'd3, 4'd4);
        run_round("full_last_on_4th", 4, 1'b1, 1'b0, 4'd0, 1'b1);
        collect_result("full_last_on_4th");
    endtask

    task automatic test_price_modes();
        set4(4'd7, 4'd2, 4'd4, 4'd1);
        run_round("first_price", 4, 1'b0, 1'b0, 4'd0, 1'b1);
        collect_result("first_price");
        run_round("second_price", 4, 1'b0, 1'b1, 4'd0, 1'b1);
        collect_result("second_price");
    endtask

    task automatic test_short_rounds();
        set4(4'd5, 4'd6, 4'd0, 4'd0);
        run_round("two_bids", 2, 1'b1, 1'b1, 4'd0, 1'b1);
        collect_result("two_bids");
        set4(4'd4, 4'd0, 4'd0, 4'd0);
        run_round("single_bid", 1, 1'b1, 1'b1, 4'd0, 1'b1);
        collect_result("single_bid");
        set4(4'd0, 4'd0, 4'd0, 4'd0);
        run_round("zero_bid", 1, 1'b1, 1'b0, 4'd0, 1'b1);
        collect_result("zero_bid");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w0;
        logic [W-1:0] b0, p0;
        logic [N:0]   n0;
        set4(4'd8, 4'd11, 4'd11, 4'd2);
        run_round("hold", 4, 1'b0, 1'b1, 4'd0, 1'b1);
        w0 = winner; b0 = winning_bid; p0 = price; n0 = num_bids;
        bid = 4'd15; bid_valid = 1'b1; res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bid_ready !== 1'b0 || res_valid !== 1'b1 || winner !== w0 ||
                winning_bid !== b0 || price !== p0 || num_bids !== n0) begin
                errors++;
                $display("FAIL hold_cycle%0d: rdy=%0b val=%0b win=%0d wb=%0d pr=%0d nb=%0d", c,
                         bid_ready, res_valid, winner, winning_bid, price, num_bids);
            end else
                $display("hold_cycle%0d: result held, bid_ready=0", c);
        end
        bid_valid = 1'b0;
        collect_result("hold");
        set4(4'd2, 4'd1, 4'd0, 4'd0);
        run_round("after_hold", 2, 1'b1, 1'b1, 4'd0, 1'b1);
        collect_result("after_hold");
    endtask

`ifdef AUCTION_RESERVE_EN
    task automatic test_reserve();
        set4(4'd3, 4'd9, 4'd5, 4'd2);
        run_round("reserve_floor", 4, 1'b0, 1'b1, 4'd8, 1'b1);
        collect_result("reserve_floor");
        run_round("reserve_unsold", 4, 1'b0, 1'b1, 4'd10, 1'b1);
        collect_result("reserve_unsold");
        run_round("reserve_first", 4, 1'b0, 1'b0, 4'd8, 1'b1);
        collect_result("reserve_first");
    endtask
`endif

    task automatic test_mid_reset();
        set4(4'd15, 4'd14, 4'd0, 4'd0);
        run_round("mid_reset_partial", 2, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset_async");
        @(negedge clk);
        rst = 1'b0;
        set4(4'd1, 4'd2, 4'd3, 4'd4);
        run_round("after_reset", 4, 1'b0, 1'b1, 4'd0, 1'b1);
        collect_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_price_modes();
        test_short_rounds();
        test_back_to_back();
`ifdef AUCTION_RESERVE_EN
        test_reserve();
`endif
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vickrey_auction_seq.md
# vickrey_auction_seq

Streaming sealed-bid auction engine: accepts up to 2**N bids, one per cycle, over a valid/ready handshake and tracks the highest and second-highest bid on the fly. At round close it presents winner index, winning bid and clearing price (first- or second-price, selected per round) on a held result handshake, then rearms for the next round. It is the sequential successor of the team's combinational tree auction. It serves MPC flows where bidders arrive serially and the round length is variable.

## Interface
- N, 2: log2 of maximum bidders per round; bidder index width.
- W, 8: bid/price width, unsigned.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bid  in  W  bid value; bidder index = arrival order within round (0-based).
- bid_valid  in  1  bid present.
- bid_last  in  1  qualifies bid_valid; closes round after this bid.
- bid_ready  out  1  engine accepting bids.
- second_price  in  1  1 = Vickrey price, 0 = first price; sampled on the round's first accepted bid.
- reserve  in  W  reserve price (only with AUCTION_RESERVE_EN); sampled with second_price.
- res_valid  out  1  result held valid.
- res_ready  in  1  result consumer ready.
- winner  out  N  winning bidder index.
- winning_bid  out  W  highest bid.
- price  out  W  clearing price.
- sold  out  1  item sold (always 1 without AUCTION_RESERVE_EN).
- num_bids  out  N+1  bids accepted in the closed round.

## Operation
- States: COLLECT, RESULT. Reset state COLLECT.
- COLLECT: bid_ready=1, res_valid=0. Accept on bid_valid&bid_ready.
- Update per accepted bid b at index i: if b > best (strict) then second<=best, best<=b, widx<=i; else if b > second then second<=b. Ties to best keep earlier bidder but raise second to b (equal bids give Vickrey price = best).
- best, second cleared to 0 at round start; first accepted bid always wins provisionally (index 0).
- Round closes on accepted bid with bid_last=1 or on the 2**N-th accepted bid, whichever first; bid_last on the 2**N-th bid is the same close.
- Close: compute price = second_price_latched ? second : best; register outputs; go RESULT.
- RESULT: res_valid=1, bid_ready=0, outputs stable; on res_valid&res_ready clear counters/trackers, return COLLECT next cycle.
- Single-bid round, Vickrey mode: price = 0.
- num_bids counts 1..2**N; width N+1 so 2**N is representable; index counter never wraps within a round.

## Timing
- Reset (async assert, sync release): bid_ready=1, res_valid=0, winner=0, winning_bid=0, price=0, sold=0, num_bids=0; round discarded.
- Throughput: one bid per cycle in COLLECT.
- Latency: res_valid rises the cycle after the closing bid is accepted.
- Result handshake: bid_ready=0 from that cycle until the cycle after res_ready seen; minimum one bubble between rounds.
- Outputs are registered, held unchanged while res_valid&!res_ready; they keep last values after handshake until next close.
- bid_valid with bid_ready=0 is ignored (no buffering); sender must hold.
- rst mid-round or mid-RESULT: all state and outputs to reset values immediately.

## Configuration
- AUCTION_RESERVE_EN defined: reserve port present. At close, if best < reserve then sold=0, winner=0, winning_bid=0, price=0; else sold=1, price = max(price, reserve) (Vickrey floor; first price unchanged since best >= reserve).
- Undefined: no reserve port; sold=1 on every result.

## Test plan
- N=2,W=4, second_price=1, bids 3,9,5,9 -> winner=1, winning_bid=9, price=9, num_bids=4, res_valid one cycle after 4th bid.
- Bids 7,2,4,1, second_price=0 then next round same bids second_price=1 -> winner=0, price 7 then price 4.
- Bids 5,6 with bid_last on 6 -> winner=1, winning_bid=6, price=5 (Vickrey), num_bids=2; single bid 4 with bid_last -> price=0.
- Hold res_ready=0 for 3 cycles with bid_valid=1 -> bid_ready=0, outputs constant, no bids consumed; res_ready=1 -> COLLECT next cycle.
- AUCTION_RESERVE_EN, Vickrey: reserve=8, bids 3,9,5,2 -> sold=1, price=8; reserve=10 -> sold=0, winner=0, price=0.
- Assert rst after 2 bids -> outputs reset; new round of 1,2,3,4 -> winner=3, unaffected by prior bids.
